// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues vend results and serves them in order as one drink-motor
// handshake followed by one hopper handshake per 0.5 coin, with stall and overflow detection.
module vend_dispense_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int TO_CYCLES  = 200,
    parameter int TO_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_vld,
    input  logic [1:0] change_cnt,
    output logic       drink_req,
    input  logic       drink_ack,
    output logic       coin_req,
    input  logic       coin_ack,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       fault,
    input  logic       fault_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE, DRINK_REQ, DRINK_REL, COIN_REQ, COIN_REL, FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      coins_q, coins_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            drink_req_q, coin_req_q, busy_q, full_q, ovf_q, fault_q;
    logic            evt, pop, push, drop, timeout;
    logic [2:0]      head;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        evt     = vend_vld | (change_cnt != 2'd0);
        pop     = (state_q == IDLE) && (cnt_q != '0);
        // A full queue still accepts when the head leaves on the same edge.
        push    = evt && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
        drop    = evt && !push;
        timeout = (to_cnt_q == TO_W'(TO_CYCLES - 1));
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        state_d = state_q;
        coins_d = coins_q;
        case (state_q)
            IDLE: if (pop) begin
                coins_d = head[1:0];
                state_d = head[2] ? DRINK_REQ : COIN_REQ;
            end
            DRINK_REQ: begin
                if (drink_ack)    state_d = DRINK_REL;
                else if (timeout) state_d = FAULT;
            end
            DRINK_REL: begin
                if (!drink_ack)   state_d = (coins_q != 2'd0) ? COIN_REQ : IDLE;
                else if (timeout) state_d = FAULT;
            end
            COIN_REQ: begin
                if (coin_ack) begin
                    coins_d = coins_q - 2'd1;
                    state_d = COIN_REL;
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            COIN_REL: begin
                if (!coin_ack)    state_d = (coins_q != 2'd0) ? COIN_REQ : IDLE;
                else if (timeout) state_d = FAULT;
            end
            FAULT:   if (fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Queue storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {vend_vld, change_cnt};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            coins_q     <= '0;
            to_cnt_q    <= '0;
            drink_req_q <= 1'b0;
            coin_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
            cnt_q   <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (state_d != state_q)
                to_cnt_q <= '0;
            else if (state_q inside {DRINK_REQ, DRINK_REL, COIN_REQ, COIN_REL})
                to_cnt_q <= to_cnt_q + 1'b1;
            // Requests follow the registered state; a timeout kills them on the fault edge.
            drink_req_q <= (state_q == DRINK_REQ) && (state_d != FAULT);
            coin_req_q  <= (state_q == COIN_REQ) && (state_d != FAULT);
            busy_q      <= (state_d != IDLE) || (cnt_d != '0);
            full_q      <= (cnt_d == CW'(FIFO_DEPTH));
            fault_q     <= (state_d == FAULT);
            if (drop)           ovf_q <= 1'b1;
            else if (fault_clr) ovf_q <= 1'b0;
        end
    end

    assign drink_req = drink_req_q;
    assign coin_req  = coin_req_q;
    assign busy      = busy_q;
    assign fifo_full = full_q;
    assign overflow  = ovf_q;
    assign fault     = fault_q;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: actuator echo model, pulse log, per-scenario checks.
module tb_vend_dispense_ctrl;
    logic       clk = 1'b0, rst = 1'b0;
    logic       vend_vld = 1'b0, drink_ack = 1'b0, coin_ack = 1'b0, fault_clr = 1'b0;
    logic [1:0] change_cnt = 2'd0;
    logic       drink_req, coin_req, busy, fifo_full, overflow, fault;

    int   total = 0, bad = 0;
    bit   echo = 1'b0;
    int   dpulses = 0, cpulses = 0, lg_n = 0;
    logic dprev = 1'b0, cprev = 1'b0;
    byte  lg [0:255];

    vend_dispense_ctrl #(.FIFO_DEPTH(4), .TO_CYCLES(200), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .vend_vld(vend_vld), .change_cnt(change_cnt),
        .drink_req(drink_req), .drink_ack(drink_ack), .coin_req(coin_req), .coin_ack(coin_ack),
        .busy(busy), .fifo_full(fifo_full), .overflow(overflow), .fault(fault),
        .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    // One clock; returns at the falling edge, logs request pulses, echoes acks if enabled.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (drink_req && !dprev) begin
            dpulses++;
            if (lg_n < 256) lg[lg_n] = 8'h44;
            lg_n++;
        end
        if (coin_req && !cprev) begin
            cpulses++;
            if (lg_n < 256) lg[lg_n] = 8'h43;
            lg_n++;
        end
        dprev = drink_req;
        cprev = coin_req;
        if (echo) begin
            drink_ack = drink_req;
            coin_ack  = coin_req;
        end
    endtask

    task automatic send(input logic v, input logic [1:0] c);
        vend_vld   = v;
        change_cnt = c;
        tick();
        vend_vld   = 1'b0;
        change_cnt = 2'd0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        total++; if (drink_req !== 1'b0) begin bad++; $display("FAIL reset_drink_req got=%b want=0", drink_req); end
        total++; if (coin_req !== 1'b0)  begin bad++; $display("FAIL reset_coin_req got=%b want=0", coin_req); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_fifo_full got=%b want=0", fifo_full); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (fault !== 1'b0)     begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_drink_change();
        int d0, c0;
        bit ok;
        echo = 1'b1;
        d0 = dpulses; c0 = cpulses;
        send(1'b1, 2'd2);
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL t1_busy_e0 got=%b want=1", busy); end
        total++; if (drink_req !== 1'b0) begin bad++; $display("FAIL t1_req_e0 got=%b want=0", drink_req); end
        tick();
        total++; if (drink_req !== 1'b0) begin bad++; $display("FAIL t1_req_e1 got=%b want=0", drink_req); end
        tick();
        total++; if (drink_req !== 1'b1) begin bad++; $display("FAIL t1_req_e2 got=%b want=1", drink_req); end
        wait_idle(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL t1_idle_timeout busy=%b want=0", busy); end
        total++; if (dpulses - d0 !== 1) begin bad++; $display("FAIL t1_drink_pulses got=%0d want=1", dpulses - d0); end
        total++; if (cpulses - c0 !== 2) begin bad++; $display("FAIL t1_coin_pulses got=%0d want=2", cpulses - c0); end
        total++; if (coin_req !== 1'b0)  begin bad++; $display("FAIL t1_coin_req_end got=%b want=0", coin_req); end
    endtask

    task automatic test_refund();
        int d0, c0;
        bit ok;
        echo = 1'b1;
        d0 = dpulses; c0 = cpulses;
        send(1'b0, 2'd1);
        tick();
        total++; if (coin_req !== 1'b0) begin bad++; $display("FAIL t2_coin_req_e1 got=%b want=0", coin_req); end
        tick();
        total++; if (coin_req !== 1'b1) begin bad++; $display("FAIL t2_coin_req_e2 got=%b want=1", coin_req); end
        wait_idle(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_idle_timeout busy=%b want=0", busy); end
        total++; if (dpulses - d0 !== 0) begin bad++; $display("FAIL t2_drink_pulses got=%0d want=0", dpulses - d0); end
        total++; if (cpulses - c0 !== 1) begin bad++; $display("FAIL t2_coin_pulses got=%0d want=1", cpulses - c0); end
    endtask

    task automatic test_overflow();
        int  l0;
        bit  ok;
        byte exp_seq [8];
        echo = 1'b0; drink_ack = 1'b0; coin_ack = 1'b0;
        exp_seq = '{8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h43, 8'h44, 8'h43};
        send(1'b1, 2'd0);
        send(1'b0, 2'd1);
        send(1'b0, 2'd2);
        send(1'b0, 2'd3);
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL t3_full_3 got=%b want=0", fifo_full); end
        send(1'b1, 2'd1);
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL t3_full_4 got=%b want=1", fifo_full); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL t3_ovf_before got=%b want=0", overflow); end
        send(1'b0, 2'd2);
        total++; if (overflow !== 1'b1)  begin bad++; $display("FAIL t3_ovf_drop got=%b want=1", overflow); end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL t3_full_drop got=%b want=1", fifo_full); end
        l0 = lg_n;
        echo = 1'b1;
        wait_idle(200, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_idle_timeout busy=%b want=0", busy); end
        total++; if (lg_n - l0 !== 8) begin bad++; $display("FAIL t3_pulse_count got=%0d want=8", lg_n - l0); end
        for (int i = 0; i < 8; i++) begin
            if (l0 + i < 256 && l0 + i < lg_n) begin
                total++;
                if (lg[l0 + i] !== exp_seq[i]) begin
                    bad++; $display("FAIL t3_order[%0d] got=%c want=%c", i, lg[l0 + i], exp_seq[i]);
                end
            end
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t3_ovf_sticky got=%b want=1", overflow); end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t3_ovf_clr got=%b want=0", overflow); end
        total++; if (fault !== 1'b0)    begin bad++; $display("FAIL t3_fault_clr got=%b want=0", fault); end
    endtask

    task automatic test_timeout();
        int d0, c0;
        bit ok;
        echo = 1'b0; drink_ack = 1'b0; coin_ack = 1'b0;
        send(1'b1, 2'd0);
        for (int i = 0; i < 5; i++) send(1'b0, 2'd1);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL t4_ovf got=%b want=1", overflow); end
        for (int i = 0; i < 195; i++) tick();
        total++; if (fault !== 1'b0)     begin bad++; $display("FAIL t4_fault_early got=%b want=0", fault); end
        total++; if (drink_req !== 1'b1) begin bad++; $display("FAIL t4_req_held got=%b want=1", drink_req); end
        tick();
        total++; if (fault !== 1'b1)     begin bad++; $display("FAIL t4_fault got=%b want=1", fault); end
        total++; if (drink_req !== 1'b0) begin bad++; $display("FAIL t4_req_drop got=%b want=0", drink_req); end
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL t4_busy_fault got=%b want=1", busy); end
        echo = 1'b1;
        d0 = dpulses; c0 = cpulses;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++; if (fault !== 1'b0)    begin bad++; $display("FAIL t4_fault_clr got=%b want=0", fault); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL t4_ovf_clr got=%b want=0", overflow); end
        tick();
        total++; if (coin_req !== 1'b0) begin bad++; $display("FAIL t4_coin_pop got=%b want=0", coin_req); end
        tick();
        total++; if (coin_req !== 1'b1) begin bad++; $display("FAIL t4_coin_next got=%b want=1", coin_req); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_idle_timeout busy=%b want=0", busy); end
        total++; if (cpulses - c0 !== 4) begin bad++; $display("FAIL t4_coin_pulses got=%0d want=4", cpulses - c0); end
        total++; if (dpulses - d0 !== 0) begin bad++; $display("FAIL t4_drink_pulses got=%0d want=0", dpulses - d0); end
    endtask

    task automatic test_reset_mid();
        int d0, c0;
        bit ok;
        echo = 1'b1;
        send(1'b0, 2'd3);
        send(1'b0, 2'd1);
        send(1'b0, 2'd1);
        tick();
        rst = 1'b0;
        tick();
        total++; if (coin_req !== 1'b0)  begin bad++; $display("FAIL t5_coin_req got=%b want=0", coin_req); end
        total++; if (drink_req !== 1'b0) begin bad++; $display("FAIL t5_drink_req got=%b want=0", drink_req); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL t5_busy got=%b want=0", busy); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL t5_fifo_full got=%b want=0", fifo_full); end
        rst = 1'b1;
        d0 = dpulses; c0 = cpulses;
        for (int i = 0; i < 10; i++) tick();
        total++; if (dpulses + cpulses - d0 - c0 !== 0) begin
            bad++; $display("FAIL t5_quiet got=%0d want=0", dpulses + cpulses - d0 - c0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_busy_after got=%b want=0", busy); end
        send(1'b0, 2'd1);
        wait_idle(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_idle_timeout busy=%b want=0", busy); end
        total++; if (cpulses - c0 !== 1) begin bad++; $display("FAIL t5_coin_pulses got=%0d want=1", cpulses - c0); end
    endtask

    task automatic test_full_pop();
        int c0;
        bit ok;
        echo = 1'b0; drink_ack = 1'b0; coin_ack = 1'b0;
        send(1'b1, 2'd0);
        for (int i = 0; i < 4; i++) send(1'b0, 2'd1);
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL t6_full got=%b want=1", fifo_full); end
        drink_ack = 1'b1;
        tick();
        drink_ack = 1'b0;
        tick();
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL t6_full_idle got=%b want=1", fifo_full); end
        send(1'b0, 2'd2);
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL t6_no_ovf got=%b want=0", overflow); end
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL t6_full_after got=%b want=1", fifo_full); end
        c0 = cpulses;
        echo = 1'b1;
        wait_idle(150, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_idle_timeout busy=%b want=0", busy); end
        total++; if (cpulses - c0 !== 6) begin bad++; $display("FAIL t6_coin_pulses got=%0d want=6", cpulses - c0); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL t6_ovf_end got=%b want=0", overflow); end
    endtask

    initial begin
        test_reset();
        test_drink_change();
        test_refund();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_full_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
